// File: rtl/msf_tx_pkg.sv
// Shared constants and helpers for the MSF time-code transmitter.
// MSF_PARITY_EN (optional macro): when defined, B bits 54..57 are replaced
// by odd parity over the A-bit groups as a frame becomes active.
package msf_tx_pkg;

  localparam int SLOTS_PER_SECOND    = 10;
  localparam int MINUTE_MARKER_SLOTS = 5;

  // Parity groups over A bits, and the seconds whose B bit carries them
  localparam int PAR_GROUPS        = 4;
  localparam int PAR_LO [PAR_GROUPS] = '{17, 25, 36, 39};
  localparam int PAR_HI [PAR_GROUPS] = '{24, 35, 38, 51};
  localparam int PAR_SEC_FIRST     = 54;
  localparam int PAR_SEC_LAST      = 57;

  typedef logic [59:0] frame_t;

  // B frame with its parity seconds overwritten by XNOR-reduce of each A group
  function automatic frame_t apply_parity(input frame_t a, input frame_t b);
    frame_t r;
    logic   p;
    r = b;
    for (int g = 0; g <= PAR_SEC_LAST - PAR_SEC_FIRST; g++) begin
      p = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if (i >= PAR_LO[g] && i <= PAR_HI[g]) p = p ^ a[i];
      end
      r[PAR_SEC_FIRST + g] = p;
    end
    return r;
  endfunction

  // Carrier suppression for a given second/slot of the active frame
  function automatic logic key_for(input logic [5:0] sec, input logic [3:0] slot,
                                   input frame_t a, input frame_t b);
    if (sec == 6'd0) return (slot < 4'(MINUTE_MARKER_SLOTS));
    return (slot == 4'd0) || (slot == 4'd1 && a[sec]) || (slot == 4'd2 && b[sec]);
  endfunction

endpackage

// File: rtl/msf_carrier_divider.sv
// Divides clk down to a one-clk carrier strobe; disabled means cleared.
module msf_carrier_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_carrier_div,
  output logic             o_carrier_pulse
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_armed;

  // Count 0..carrier_div while enabled; r_armed keeps the strobe low until
  // the first edge after reset so every output is 0 while in reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_div_cnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (!i_enable || r_div_cnt >= i_carrier_div) r_div_cnt <= '0;
      else                                         r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // The strobe is high on the clk whose edge wraps the divider
  assign o_carrier_pulse = r_armed & i_enable & (r_div_cnt >= i_carrier_div);

endmodule

// File: rtl/msf_timecode_tx.sv
// MSF time-code transmitter: carrier/second/minute counting, slot keying and
// a staged 60-second A/B frame. Optional macro: MSF_PARITY_EN.
module msf_timecode_tx
  import msf_tx_pkg::*;
#(
  parameter int SECONDS_MINUTE = 59,
  parameter int FREQ_W         = 17,
  parameter int DIV_W          = 16
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [DIV_W-1:0]  carrier_div,
  input  logic [FREQ_W-1:0] msf_frequency,
  input  logic [FREQ_W-1:0] ms100_count,
  input  logic [59:0]       bits_a,
  input  logic [59:0]       bits_b,
  input  logic              bits_valid,
  output logic              bits_ready,
  output logic              carrier_pulse,
  output logic [FREQ_W-1:0] msf_carrier_counter,
  output logic [5:0]        second_counter,
  output logic              key_off,
  output logic              one_sec_marker,
  output logic              minute_marker,
  output logic              underrun
);

  logic              w_pulse;
  logic [FREQ_W-1:0] r_carrier_cnt, w_carrier_cnt_nxt;
  logic [5:0]        r_sec, w_sec_nxt;
  logic [FREQ_W-1:0] r_slot_sub, w_slot_sub_nxt;
  logic [3:0]        r_slot, w_slot_nxt;
  logic              w_sec_bnd, w_min_bnd;
  logic              r_one_sec, r_minute, r_key_off, r_underrun;
  frame_t            r_stg_a, r_stg_b, r_act_a, r_act_b, w_act_a_nxt, w_act_b_nxt;
  logic              r_stg_full, w_stg_full_nxt, r_bits_ready, w_capture;

  msf_carrier_divider #(.DIV_W(DIV_W)) u_div (
    .clk             (clk),
    .aresetn         (aresetn),
    .i_enable        (enable),
    .i_carrier_div   (carrier_div),
    .o_carrier_pulse (w_pulse)
  );

  // Next carrier/second/slot counts; >= compares let a lowered limit wrap at once
  always_comb begin
    w_carrier_cnt_nxt = r_carrier_cnt;
    w_sec_nxt         = r_sec;
    w_slot_sub_nxt    = r_slot_sub;
    w_slot_nxt        = r_slot;
    w_sec_bnd         = 1'b0;
    if (w_pulse) begin
      if (r_carrier_cnt >= msf_frequency - FREQ_W'(1)) begin
        w_carrier_cnt_nxt = '0;
        w_sec_bnd         = 1'b1;
        w_sec_nxt         = (r_sec >= 6'(SECONDS_MINUTE)) ? 6'd0 : r_sec + 6'd1;
        w_slot_sub_nxt    = '0;
        w_slot_nxt        = '0;
      end else begin
        w_carrier_cnt_nxt = r_carrier_cnt + FREQ_W'(1);
        if (r_slot_sub >= ms100_count - FREQ_W'(1)) begin
          w_slot_sub_nxt = '0;
          if (r_slot < 4'(SLOTS_PER_SECOND - 1)) w_slot_nxt = r_slot + 4'd1;
        end else begin
          w_slot_sub_nxt = r_slot_sub + FREQ_W'(1);
        end
      end
    end
  end

  assign w_min_bnd = w_sec_bnd && (w_sec_nxt == 6'd0);

  // Handshake: a frame moves into staging on any clk with bits_valid and
  // bits_ready both high; bits_ready is the registered inverse of staging-full,
  // so a held bits_valid simply waits for the staging slot to drain.
  assign w_capture = bits_valid & r_bits_ready;

  // Staging -> active transfer at the minute boundary; staging state as seen
  // before this clk decides it, so a same-clk capture waits for the next minute
  always_comb begin
    w_act_a_nxt    = r_act_a;
    w_act_b_nxt    = r_act_b;
    w_stg_full_nxt = r_stg_full;
    if (w_min_bnd && r_stg_full) begin
      w_act_a_nxt    = r_stg_a;
`ifdef MSF_PARITY_EN
      w_act_b_nxt    = apply_parity(r_stg_a, r_stg_b);
`else
      w_act_b_nxt    = r_stg_b;
`endif
      w_stg_full_nxt = 1'b0;
    end
    if (w_capture) w_stg_full_nxt = 1'b1;
  end

  // Counters, markers and keying all register on the same edge
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_carrier_cnt <= '0;
      r_sec         <= '0;
      r_slot_sub    <= '0;
      r_slot        <= '0;
      r_one_sec     <= 1'b0;
      r_minute      <= 1'b0;
      r_key_off     <= 1'b0;
    end else begin
      r_carrier_cnt <= w_carrier_cnt_nxt;
      r_sec         <= w_sec_nxt;
      r_slot_sub    <= w_slot_sub_nxt;
      r_slot        <= w_slot_nxt;
      r_one_sec     <= w_sec_bnd;
      r_minute      <= w_min_bnd;
      r_key_off     <= enable & key_for(w_sec_nxt, w_slot_nxt, w_act_a_nxt, w_act_b_nxt);
    end
  end

  // Frame staging, active frame, ready flag and sticky underrun
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_stg_a      <= '0;
      r_stg_b      <= '0;
      r_stg_full   <= 1'b0;
      r_act_a      <= '0;
      r_act_b      <= '0;
      r_bits_ready <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_stg_a <= bits_a;
        r_stg_b <= bits_b;
      end
      r_stg_full   <= w_stg_full_nxt;
      r_act_a      <= w_act_a_nxt;
      r_act_b      <= w_act_b_nxt;
      r_bits_ready <= !w_stg_full_nxt;
      if (w_min_bnd && !r_stg_full) r_underrun <= 1'b1;
    end
  end

  assign carrier_pulse       = w_pulse;
  assign msf_carrier_counter = r_carrier_cnt;
  assign second_counter      = r_sec;
  assign key_off             = r_key_off;
  assign one_sec_marker      = r_one_sec;
  assign minute_marker       = r_minute;
  assign underrun            = r_underrun;
  assign bits_ready          = r_bits_ready;

endmodule

// File: tb/tb_msf_timecode_tx.sv
// Bench for msf_timecode_tx: directed steps with random frames/enable gaps,
// checked every clk against an absolute-pulse-count reference model.
module tb_msf_timecode_tx;

  localparam int FREQ_W = 17;
  localparam int DIV_W  = 16;
  localparam int FREQ   = 100;
  localparam int MS100  = 10;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              enable = 1'b0;
  logic [DIV_W-1:0]  carrier_div = 16'd3;
  logic [FREQ_W-1:0] msf_frequency = 17'(FREQ);
  logic [FREQ_W-1:0] ms100_count = 17'(MS100);
  logic [59:0]       bits_a = '0;
  logic [59:0]       bits_b = '0;
  logic              bits_valid = 1'b0;
  logic              bits_ready;
  logic              carrier_pulse;
  logic [FREQ_W-1:0] msf_carrier_counter;
  logic [5:0]        second_counter;
  logic              key_off;
  logic              one_sec_marker;
  logic              minute_marker;
  logic              underrun;

  always #5 clk = ~clk;

  msf_timecode_tx dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .enable              (enable),
    .carrier_div         (carrier_div),
    .msf_frequency       (msf_frequency),
    .ms100_count         (ms100_count),
    .bits_a              (bits_a),
    .bits_b              (bits_b),
    .bits_valid          (bits_valid),
    .bits_ready          (bits_ready),
    .carrier_pulse       (carrier_pulse),
    .msf_carrier_counter (msf_carrier_counter),
    .second_counter      (second_counter),
    .key_off             (key_off),
    .one_sec_marker      (one_sec_marker),
    .minute_marker       (minute_marker),
    .underrun            (underrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Everything derives from m_p, the total carrier pulses since reset:
  // second = (m_p / FREQ) % 60, carrier index = m_p % FREQ, slot = min(index/MS100, 9).
  int          m_p = 0;
  int          m_phase = 0;
  bit          m_armed = 0;
  bit          m_full = 0, m_ready = 0, m_under = 0;
  bit          m_key = 0, m_sec_mk = 0, m_min_mk = 0;
  logic [59:0] m_stg_a = '0, m_stg_b = '0, m_act_a = '0, m_act_b = '0;
  int          en_edges = 0;
  bit          m_pulse, m_cap;
  int          m_sec, m_slot;

  function automatic logic [59:0] model_b(input logic [59:0] a, input logic [59:0] b);
    logic [59:0] r;
    r = b;
`ifdef MSF_PARITY_EN
    begin
      int lo [4];
      int hi [4];
      int ones;
      lo = '{17, 25, 36, 39};
      hi = '{24, 35, 38, 51};
      for (int g = 0; g < 4; g++) begin
        ones = 0;
        for (int i = lo[g]; i <= hi[g]; i++) ones += int'(a[i]);
        r[54 + g] = (ones % 2 == 0);
      end
    end
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (!aresetn) begin
      m_p = 0; m_phase = 0; m_armed = 0; m_full = 0; m_ready = 0; m_under = 0;
      m_key = 0; m_sec_mk = 0; m_min_mk = 0;
      m_act_a = '0; m_act_b = '0;
    end else begin
      m_pulse = 0;
      if (enable) begin
        if (m_phase == int'(carrier_div)) begin
          m_phase = 0;
          m_pulse = m_armed;
        end else begin
          m_phase++;
        end
        en_edges++;
      end else begin
        m_phase = 0;
      end
      m_armed  = 1;
      m_sec_mk = 0;
      m_min_mk = 0;
      m_cap    = bits_valid && m_ready;
      if (m_pulse) begin
        m_p++;
        if (m_p % FREQ == 0) begin
          m_sec_mk = 1;
          if ((m_p / FREQ) % 60 == 0) begin
            m_min_mk = 1;
            if (m_full) begin
              m_act_a = m_stg_a;
              m_act_b = model_b(m_stg_a, m_stg_b);
              m_full  = 0;
            end else begin
              m_under = 1;
            end
          end
        end
      end
      if (m_cap) begin
        m_stg_a = bits_a;
        m_stg_b = bits_b;
        m_full  = 1;
      end
      m_ready = !m_full;
      m_sec   = (m_p / FREQ) % 60;
      m_slot  = (m_p % FREQ) / MS100;
      if (m_slot > 9) m_slot = 9;
      if (m_sec == 0) m_key = (m_slot < 5);
      else m_key = (m_slot == 0) || (m_slot == 1 && m_act_a[m_sec]) || (m_slot == 2 && m_act_b[m_sec]);
      m_key = m_key && enable;
    end
  end

  // ---------------- scoreboard: every output, every clk ----------------
  always @(negedge clk) begin
    #2;
    check("carrier_pulse", 64'(carrier_pulse), 64'(m_armed && enable && (m_phase == int'(carrier_div))));
    check("carrier_cnt", 64'(msf_carrier_counter), 64'(m_p % FREQ));
    check("second", 64'(second_counter), 64'((m_p / FREQ) % 60));
    check("key_off", 64'(key_off), 64'(m_key));
    check("one_sec_marker", 64'(one_sec_marker), 64'(m_sec_mk));
    check("minute_marker", 64'(minute_marker), 64'(m_min_mk));
    check("bits_ready", 64'(bits_ready), 64'(m_ready));
    check("underrun", 64'(underrun), 64'(m_under));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_p(input int target, input int budget);
    int i;
    i = 0;
    while (m_p < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_pulses", 64'(m_p >= target), 64'(1));
  endtask

  task automatic offer(input logic [59:0] a, input logic [59:0] b, input int budget, output bit ok);
    bit rdy;
    bits_a     = a;
    bits_b     = b;
    bits_valid = 1'b1;
    ok         = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      rdy = bits_ready;
      @(negedge clk);
      ok = rdy;
    end
  endtask

  function automatic logic [59:0] rand_frame();
    return {28'($urandom()), 32'($urandom())};
  endfunction

  // ---------------- directed sequence ----------------
  logic [59:0] f1_a, f1_b, f2_a, f2_b, f3_a, f3_b;
  bit          ok;
  int          e0, i;

  initial begin
    f1_a = rand_frame(); f1_b = rand_frame();
    f1_a[1] = 1'b1; f1_b[1] = 1'b0;
    f1_a[2] = 1'b0; f1_b[2] = 1'b1;
    f1_a[3] = 1'b1; f1_b[3] = 1'b1;
    f1_a[24:17] = 8'h01; f1_b[54] = 1'b0;
    f2_a = rand_frame(); f2_b = rand_frame();
    f2_a[24:17] = 8'h00; f2_b[54] = 1'b0;
    f3_a = rand_frame(); f3_b = rand_frame();

    repeat (4) @(negedge clk);
    aresetn = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(bits_ready), 64'(1));

    // Second-0 marker: off through slot 4, on from slot 5
    wait_p(49, 400);
    check("marker_slot4", 64'(key_off), 64'(1));
    wait_p(50, 20);
    check("marker_slot5", 64'(key_off), 64'(0));

    // Second length in clks
    wait_p(100, 400);
    e0 = en_edges;
    wait_p(200, 600);
    check("clks_per_second", 64'(en_edges - e0), 64'(400));

    // Freeze mid-second 7
    wait_p(700, 3000);
    check("sec7_marker", 64'(one_sec_marker), 64'(1));
    e0 = en_edges;
    wait_p(705, 40);
    enable = 1'b0;
    repeat (50) @(negedge clk);
    check("frozen_cnt", 64'(msf_carrier_counter), 64'(5));
    check("frozen_sec", 64'(second_counter), 64'(7));
    check("frozen_key", 64'(key_off), 64'(0));
    enable = 1'b1;
    wait_p(800, 600);
    check("sec7_enabled_clks", 64'(en_edges - e0), 64'(400));

    // Stage frame 1 during second 8
    offer(f1_a, f1_b, 10, ok);
    bits_valid = 1'b0;
    check("f1_accepted", 64'(ok), 64'(1));
    check("ready_low_when_full", 64'(bits_ready), 64'(0));

    // Switch to one carrier per clk, changed while the divider is idle
    i = 0;
    while (m_phase != 0 && i < 10) begin @(negedge clk); i++; end
    enable = 1'b0;
    carrier_div = 16'd0;
    repeat (3) @(negedge clk);
    enable = 1'b1;

    // Minute 1 keying with frame 1
    wait_p(6105, 8000);
    check("m1_s1_slot0", 64'(key_off), 64'(1));
    wait_p(6115, 20);
    check("m1_s1_slot1", 64'(key_off), 64'(1));
    wait_p(6125, 20);
    check("m1_s1_slot2", 64'(key_off), 64'(0));
    wait_p(6215, 100);
    check("m1_s2_slot1", 64'(key_off), 64'(0));
    wait_p(6225, 20);
    check("m1_s2_slot2", 64'(key_off), 64'(1));
    wait_p(6325, 120);
    check("m1_s3_slot2", 64'(key_off), 64'(1));
    wait_p(6335, 20);
    check("m1_s3_slot3", 64'(key_off), 64'(0));

    // Random enable gaps, no frame offered: underrun at the next minute
    i = 0;
    while (m_p < 12000 && i < 20000) begin
      @(negedge clk);
      enable = ($urandom_range(0, 9) != 0);
      i++;
    end
    enable = 1'b1;
    check("reach_minute2", 64'(m_p >= 12000), 64'(1));
    check("m2_minute_marker", 64'(minute_marker), 64'(1));
    check("m2_underrun", 64'(underrun), 64'(1));
    check("m2_ready", 64'(bits_ready), 64'(1));

    // Two frames back to back with bits_valid held
    offer(f2_a, f2_b, 10, ok);
    check("f2_accepted", 64'(ok), 64'(1));
    offer(f3_a, f3_b, 8000, ok);
    bits_valid = 1'b0;
    check("f3_accepted", 64'(ok), 64'(1));
    check("f3_capture_sec", 64'(second_counter), 64'(0));
    check("f3_capture_cnt", 64'(msf_carrier_counter), 64'(1));
    check("f3_ready_low", 64'(bits_ready), 64'(0));

    // Minute 3 (frame 2, parity seconds included) into minute 4 (frame 3)
    i = 0;
    while (m_p < 24500 && i < 12000) begin
      @(negedge clk);
      enable = ($urandom_range(0, 7) != 0);
      i++;
    end
    enable = 1'b1;
    check("reach_minute4", 64'(m_p >= 24500), 64'(1));
    check("underrun_sticky", 64'(underrun), 64'(1));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
